// File: rtl/encoder_channel_ctrl.sv
// -----------------------------------------------------------------------------
// encoder_channel_ctrl
//
// Turns a bouncy quadrature rotary encoder plus a push button into three
// editable colour-channel values (R, G, B). The button cycles the channel
// being edited; each decoded encoder step moves the selected channel by STEP,
// either clamping at the limits or wrapping modulo 2^WIDTH.
//
// Ports
//   clk      : clock, all state changes on the rising edge
//   reset    : synchronous, active-high reset
//   enc_a    : raw quadrature phase A (asynchronous, may bounce)
//   enc_b    : raw quadrature phase B (asynchronous, may bounce)
//   btn      : raw channel-select button, active-high (asynchronous, may bounce)
//   value_r  : red channel value
//   value_g  : green channel value
//   value_b  : blue channel value
//   sel      : channel being edited, 0=R 1=G 2=B
//   update   : one-cycle pulse in the cycle after a channel value changed
// -----------------------------------------------------------------------------
module encoder_channel_ctrl #(
  parameter int WIDTH           = 8,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int STEP            = 1,
  parameter int SATURATE        = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enc_a,
  input  logic             enc_b,
  input  logic             btn,
  output logic [WIDTH-1:0] value_r,
  output logic [WIDTH-1:0] value_g,
  output logic [WIDTH-1:0] value_b,
  output logic [1:0]       sel,
  output logic             update
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [WIDTH:0]   STEP_X   = (WIDTH+1)'(STEP);
  localparam logic [WIDTH:0]   MAX_X    = {1'b0, {WIDTH{1'b1}}};

  typedef enum logic [1:0] {
    SEL_R = 2'd0,
    SEL_G = 2'd1,
    SEL_B = 2'd2
  } sel_state_t;

  // Bit 0 = phase A, bit 1 = phase B, bit 2 = button.
  logic [2:0]       sync1;
  logic [2:0]       sync2;
  logic [2:0]       deb;
  logic [2:0]       prev;
  logic [CNT_W-1:0] cnt [3];

  sel_state_t       state;
  sel_state_t       state_next;

  logic             step_up;
  logic             step_dn;
  logic             btn_rise;
  logic [WIDTH-1:0] cur_value;
  logic [WIDTH-1:0] new_value;
  logic             value_changed;

  // ---------------------------------------------------------------------------
  // Synchronize and debounce the three raw inputs. A change is accepted only
  // after DEBOUNCE_CYCLES consecutive cycles of disagreement with deb; any
  // cycle of agreement throws the partial count away.
  // ---------------------------------------------------------------------------
  // NOTE: every clocked register uses <= so all of them sample pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1 <= '0;
      sync2 <= '0;
      deb   <= '0;
      prev  <= '0;
      for (int i = 0; i < 3; i++) cnt[i] <= '0;
    end else begin
      sync1 <= {btn, enc_b, enc_a};
      sync2 <= sync1;
      prev  <= deb;
      for (int i = 0; i < 3; i++) begin
        if (sync2[i] == deb[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CNT_LAST) begin
          deb[i] <= sync2[i];
          cnt[i] <= '0;
        end else begin
          cnt[i] <= cnt[i] + CNT_W'(1);
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Quadrature decode on {deb_a, prev_a, deb_b, prev_b}. Only a single-phase
  // change is a step; simultaneous changes are ambiguous and ignored.
  // ---------------------------------------------------------------------------
  // NOTE: defaults first so no path through always_comb leaves a latch behind.
  always_comb begin
    step_up = 1'b0;
    step_dn = 1'b0;
    case ({deb[0], prev[0], deb[1], prev[1]})
      4'b1000, 4'b0111: step_up = 1'b1;
      4'b0010, 4'b1101: step_dn = 1'b1;
      default: ;
    endcase
  end

  assign btn_rise = deb[2] & ~prev[2];

  // One extra bit of headroom exposes both overflow (sum above MAX_X) and
  // underflow (borrow into the top bit); in wrap mode it is simply dropped.
  function automatic logic [WIDTH-1:0] step_value(input logic [WIDTH-1:0] v,
                                                  input logic             up);
    logic [WIDTH:0] sum;
    logic [WIDTH:0] diff;
    sum  = {1'b0, v} + STEP_X;
    diff = {1'b0, v} - STEP_X;
    if (up) begin
      if ((SATURATE != 0) && (sum > MAX_X)) return {WIDTH{1'b1}};
      return sum[WIDTH-1:0];
    end
    if ((SATURATE != 0) && diff[WIDTH]) return '0;
    return diff[WIDTH-1:0];
  endfunction

  always_comb begin
    case (state)
      SEL_G:   cur_value = value_g;
      SEL_B:   cur_value = value_b;
      default: cur_value = value_r;
    endcase
    new_value     = step_value(cur_value, step_up);
    // A clamped step leaves the value alone and must not raise update.
    value_changed = (step_up | step_dn) && (new_value != cur_value);
  end

  // The step targets the channel selected before this edge, even when the
  // button advances sel on the same edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      value_r <= '0;
      value_g <= '0;
      value_b <= '0;
      update  <= 1'b0;
    end else begin
      update <= value_changed;
      if (value_changed) begin
        case (state)
          SEL_G:   value_g <= new_value;
          SEL_B:   value_b <= new_value;
          default: value_r <= new_value;
        endcase
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Channel-select FSM: R -> G -> B -> R on each debounced button press.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) state <= SEL_R;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    if (btn_rise) begin
      case (state)
        SEL_R:   state_next = SEL_G;
        SEL_G:   state_next = SEL_B;
        default: state_next = SEL_R;
      endcase
    end
  end

  assign sel = state;

endmodule

// File: tb/tb_encoder_channel_ctrl.sv
// -----------------------------------------------------------------------------
// tb_encoder_channel_ctrl
//
// Drives a saturating and a wrapping instance with the same raw encoder and
// button waveforms. Expected values come from a table of hand-worked detent
// sequences and from a behavioural model that tracks channel values and the
// selected channel directly from settled encoder/button transitions.
// -----------------------------------------------------------------------------
module tb_encoder_channel_ctrl;

  localparam int W   = 8;
  localparam int DEB = 4;
  localparam int MAXV = 255;

  logic       clk = 1'b0;
  logic       reset;
  logic       a_raw, b_raw, btn_raw;
  logic [W-1:0] r_s, g_s, b_s, r_w, g_w, b_w;
  logic [1:0] sel_s, sel_w;
  logic       upd_s, upd_w;

  always #5 clk = ~clk;

  encoder_channel_ctrl #(.WIDTH(W), .DEBOUNCE_CYCLES(DEB), .STEP(1), .SATURATE(1)) dut_sat (
    .clk(clk), .reset(reset), .enc_a(a_raw), .enc_b(b_raw), .btn(btn_raw),
    .value_r(r_s), .value_g(g_s), .value_b(b_s), .sel(sel_s), .update(upd_s)
  );

  encoder_channel_ctrl #(.WIDTH(W), .DEBOUNCE_CYCLES(DEB), .STEP(1), .SATURATE(0)) dut_wrap (
    .clk(clk), .reset(reset), .enc_a(a_raw), .enc_b(b_raw), .btn(btn_raw),
    .value_r(r_w), .value_g(g_w), .value_b(b_w), .sel(sel_w), .update(upd_w)
  );

  int total = 0;
  int bad   = 0;

  // Model state: channel values for each instance, selected channel, and the
  // number of update cycles expected / observed since the last clear.
  int m_s [3];
  int m_w [3];
  int m_sel;
  int eu_s, eu_w, cu_s, cu_w;

  always @(negedge clk) begin
    if (upd_s === 1'b1) cu_s++;
    if (upd_w === 1'b1) cu_w++;
  end

  typedef struct {
    logic a;
    logic b;
    logic bt;
    int   r;
    int   g;
    int   bv;
    int   sel;
    int   upd;
  } vec_t;

  vec_t tbl [18];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic clr_counts();
    cu_s = 0; cu_w = 0; eu_s = 0; eu_w = 0;
  endtask

  task automatic model_step(input int d);
    int ns, nw;
    ns = m_s[m_sel] + d;
    if (ns > MAXV) ns = MAXV;
    if (ns < 0)    ns = 0;
    nw = (m_w[m_sel] + d + MAXV + 1) % (MAXV + 1);
    if (ns != m_s[m_sel]) eu_s++;
    if (nw != m_w[m_sel]) eu_w++;
    m_s[m_sel] = ns;
    m_w[m_sel] = nw;
  endtask

  // Apply new raw levels and let the model react. In quadrature, moving the
  // phase that now differs from the other one is a forward step; moving B so
  // it differs from A is a backward step.
  task automatic drive(input logic a, input logic b, input logic bt);
    int d;
    d = 0;
    if (a !== a_raw && b === b_raw)      d = (a != b_raw) ? 1 : 0;
    else if (b !== b_raw && a === a_raw) d = (b != a_raw) ? -1 : 0;
    if (d != 0) model_step(d);
    if (bt && !btn_raw) m_sel = (m_sel + 1) % 3;
    a_raw = a; b_raw = b; btn_raw = bt;
  endtask

  task automatic act(input logic a, input logic b, input logic bt, input int hold);
    @(negedge clk);
    clr_counts();
    drive(a, b, bt);
    repeat (hold) @(negedge clk);
  endtask

  task automatic set_raw(input int w, input logic v);
    case (w)
      0: a_raw = v;
      1: b_raw = v;
      default: btn_raw = v;
    endcase
  endtask

  function automatic logic get_raw(input int w);
    case (w)
      0: return a_raw;
      1: return b_raw;
      default: return btn_raw;
    endcase
  endfunction

  task automatic check_wrap_model(input string tag);
    check({tag, " wrap r"},   32'(r_w),   32'(m_w[0]));
    check({tag, " wrap g"},   32'(g_w),   32'(m_w[1]));
    check({tag, " wrap b"},   32'(b_w),   32'(m_w[2]));
    check({tag, " wrap sel"}, 32'(sel_w), 32'(m_sel));
    check({tag, " wrap upd"}, 32'(cu_w),  32'(eu_w));
  endtask

  task automatic check_model(input string tag);
    check({tag, " sat r"},   32'(r_s),   32'(m_s[0]));
    check({tag, " sat g"},   32'(g_s),   32'(m_s[1]));
    check({tag, " sat b"},   32'(b_s),   32'(m_s[2]));
    check({tag, " sat sel"}, 32'(sel_s), 32'(m_sel));
    check({tag, " sat upd"}, 32'(cu_s),  32'(eu_s));
    check_wrap_model(tag);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    a_raw = 1'b0; b_raw = 1'b0; btn_raw = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      m_s[i] = 0;
      m_w[i] = 0;
    end
    m_sel = 0;
    clr_counts();
  endtask

  task automatic press(input string tag);
    act(a_raw, b_raw, 1'b1, 12);
    check_model({tag, " press"});
    act(a_raw, b_raw, 1'b0, 12);
    check_model({tag, " release"});
  endtask

  // Short pulses that return to the original level never reach acceptance.
  task automatic bounce(input int w, input logic nv, input int n);
    for (int k = 0; k < n; k++) begin
      set_raw(w, nv);
      repeat ($urandom_range(1, DEB - 1)) @(negedge clk);
      set_raw(w, !nv);
      repeat ($urandom_range(1, DEB - 1)) @(negedge clk);
    end
  endtask

  initial begin
    tbl[0]  = '{1'b1, 1'b0, 1'b0, 2, 0, 0, 0, 1};
    tbl[1]  = '{1'b1, 1'b1, 1'b0, 2, 0, 0, 0, 0};
    tbl[2]  = '{1'b0, 1'b1, 1'b0, 3, 0, 0, 0, 1};
    tbl[3]  = '{1'b0, 1'b0, 1'b0, 3, 0, 0, 0, 0};
    tbl[4]  = '{1'b1, 1'b0, 1'b0, 4, 0, 0, 0, 1};
    tbl[5]  = '{1'b1, 1'b1, 1'b0, 4, 0, 0, 0, 0};
    tbl[6]  = '{1'b0, 1'b1, 1'b0, 5, 0, 0, 0, 1};
    tbl[7]  = '{1'b0, 1'b0, 1'b0, 5, 0, 0, 0, 0};
    tbl[8]  = '{1'b1, 1'b0, 1'b0, 6, 0, 0, 0, 1};
    tbl[9]  = '{1'b1, 1'b1, 1'b0, 6, 0, 0, 0, 0};
    tbl[10] = '{1'b0, 1'b1, 1'b0, 7, 0, 0, 0, 1};
    tbl[11] = '{1'b0, 1'b0, 1'b0, 7, 0, 0, 0, 0};
    tbl[12] = '{1'b0, 1'b0, 1'b1, 7, 0, 0, 1, 0};
    tbl[13] = '{1'b0, 1'b0, 1'b0, 7, 0, 0, 1, 0};
    tbl[14] = '{1'b0, 1'b1, 1'b0, 7, 0, 0, 1, 0};
    tbl[15] = '{1'b1, 1'b1, 1'b0, 7, 0, 0, 1, 0};
    tbl[16] = '{1'b1, 1'b0, 1'b0, 7, 0, 0, 1, 0};
    tbl[17] = '{1'b0, 1'b0, 1'b0, 7, 0, 0, 1, 0};

    // ---- reset state ----
    reset = 1'b1;
    a_raw = 1'b0; b_raw = 1'b0; btn_raw = 1'b0;
    repeat (3) @(negedge clk);
    check("reset r", 32'(r_s), 0);
    check("reset g", 32'(g_s), 0);
    check("reset b", 32'(b_s), 0);
    check("reset sel", 32'(sel_s), 0);
    check("reset upd", 32'(upd_s), 0);
    do_reset();
    repeat (10) @(negedge clk);
    check_model("release idle");

    // ---- clean increment with exact latency ----
    clr_counts();
    drive(1'b1, 1'b0, 1'b0);
    for (int e = 1; e <= 8; e++) begin
      @(posedge clk);
      #1;
      check($sformatf("latency r edge%0d", e), 32'(r_s), (e >= DEB + 3) ? 1 : 0);
      check($sformatf("latency upd edge%0d", e), 32'(upd_s), (e == DEB + 3) ? 1 : 0);
      check($sformatf("latency wrap r edge%0d", e), 32'(r_w), (e >= DEB + 3) ? 1 : 0);
    end
    @(negedge clk);
    check_model("clean inc");
    act(1'b0, 1'b0, 1'b0, 10);
    check_model("a fall b low");

    // ---- table: three CW detents, button, one CCW detent on G ----
    for (int i = 0; i < 18; i++) begin
      act(tbl[i].a, tbl[i].b, tbl[i].bt, 12);
      check($sformatf("tbl%0d r", i),   32'(r_s),   32'(tbl[i].r));
      check($sformatf("tbl%0d g", i),   32'(g_s),   32'(tbl[i].g));
      check($sformatf("tbl%0d b", i),   32'(b_s),   32'(tbl[i].bv));
      check($sformatf("tbl%0d sel", i), 32'(sel_s), 32'(tbl[i].sel));
      check($sformatf("tbl%0d upd", i), 32'(cu_s),  32'(tbl[i].upd));
      check_wrap_model($sformatf("tbl%0d", i));
    end

    // ---- glitch rejection ----
    @(negedge clk);
    clr_counts();
    a_raw = 1'b1;
    repeat (DEB - 1) @(negedge clk);
    a_raw = 1'b0;
    repeat (12) @(negedge clk);
    check_model("glitch 3cyc");
    for (int w = 0; w < 3; w++) begin
      clr_counts();
      for (int t = 0; t < 10; t++) begin
        set_raw(w, !get_raw(w));
        repeat ($urandom_range(1, DEB - 1)) @(negedge clk);
      end
      repeat (12) @(negedge clk);
      check_model($sformatf("toggle burst in%0d", w));
    end

    // ---- sel wrap: back to R, then three presses R->G->B->R ----
    while (m_sel != 0) press("to R");
    press("wrap 1");
    press("wrap 2");
    press("wrap 3");

    // ---- step and press debounced on the same edge ----
    act(1'b1, 1'b0, 1'b1, 12);
    check("coincide r", 32'(r_s), 8);
    check("coincide sel", 32'(sel_s), 1);
    check("coincide upd", 32'(cu_s), 1);
    check_model("coincide");
    act(1'b0, 1'b0, 1'b0, 12);
    check_model("coincide release");

    // ---- preload R to 255, then one more step ----
    while (m_sel != 0) press("to R2");
    while (m_s[0] < MAXV) begin
      act(1'b1, 1'b0, 1'b0, 10);
      act(1'b0, 1'b0, 1'b0, 10);
    end
    check_model("preload 255");
    act(1'b1, 1'b0, 1'b0, 10);
    check("sat hold r", 32'(r_s), 255);
    check("sat hold upd", 32'(cu_s), 0);
    check("wrap r", 32'(r_w), 0);
    check("wrap upd", 32'(cu_w), 1);
    check_model("past top");
    act(1'b0, 1'b0, 1'b0, 10);

    // ---- randomized actions with bounce, against the model ----
    for (int it = 0; it < 80; it++) begin
      int op;
      int w;
      logic nv;
      op = $urandom_range(0, 3);
      case (op)
        0, 1: begin
          nv = !get_raw(op);
          bounce(op, nv, $urandom_range(0, 2));
          if (op == 0) act(nv, b_raw, btn_raw, 10);
          else         act(a_raw, nv, btn_raw, 10);
          check_model($sformatf("rand%0d step", it));
        end
        2: press($sformatf("rand%0d", it));
        default: begin
          w = $urandom_range(0, 2);
          clr_counts();
          bounce(w, !get_raw(w), 1);
          repeat (10) @(negedge clk);
          check_model($sformatf("rand%0d glitch", it));
        end
      endcase
    end

    // ---- reset mid-operation ----
    do_reset();
    act(1'b0, 1'b0, 1'b0, 10);
    press("to G");
    press("to B");
    for (int k = 0; k < 5; k++) begin
      act(1'b1, 1'b0, 1'b0, 10);
      act(1'b0, 1'b0, 1'b0, 10);
    end
    check("preload b", 32'(b_s), 5);
    check_model("preload b");
    @(negedge clk);
    a_raw = 1'b1;
    repeat (DEB) @(negedge clk);
    reset = 1'b1;
    a_raw = 1'b0;
    @(posedge clk);
    #1;
    check("midrst r", 32'(r_s), 0);
    check("midrst g", 32'(g_s), 0);
    check("midrst b", 32'(b_s), 0);
    check("midrst sel", 32'(sel_s), 0);
    check("midrst upd", 32'(upd_s), 0);
    check("midrst wrap b", 32'(b_w), 0);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      m_s[i] = 0;
      m_w[i] = 0;
    end
    m_sel = 0;
    clr_counts();
    repeat (20) @(negedge clk);
    check_model("after midrst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/encoder_channel_ctrl.md
ENCODER_CHANNEL_CTRL -- requirements
Module: encoder_channel_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 8, the width of each channel value.
REQ-002 SHALL have parameter DEBOUNCE_CYCLES, default 16, range 1..255: the number of consecutive mismatch cycles needed to accept an input change.
REQ-003 SHALL have parameter STEP, default 1: the magnitude of each value change, range 1..2^WIDTH-1.
REQ-004 SHALL have parameter SATURATE, default 1: 1 = clamp at the limits, 0 = modulo-2^WIDTH wrap.
REQ-005 SHALL have port clk  input  1  clock; all state changes on the rising edge.
REQ-006 SHALL have port reset  input  1  reset, synchronous, active-high.
REQ-007 SHALL have port enc_a  input  1  raw quadrature phase A, asynchronous, may bounce.
REQ-008 SHALL have port enc_b  input  1  raw quadrature phase B, asynchronous, may bounce.
REQ-009 SHALL have port btn  input  1  raw channel-select push button, active-high, asynchronous, may bounce.
REQ-010 SHALL have port value_r  output  WIDTH  red channel value.
REQ-011 SHALL have port value_g  output  WIDTH  green channel value.
REQ-012 SHALL have port value_b  output  WIDTH  blue channel value.
REQ-013 SHALL have port sel  output  2  current edit channel: 0=R, 1=G, 2=B; 3 is never driven.
REQ-014 SHALL have port update  output  1  one-cycle pulse, high in the cycle after any channel value actually changed.

Function
REQ-015 SHALL pass enc_a, enc_b and btn each through a 2-flop synchronizer (sync1, sync2).
REQ-016 SHALL debounce each synchronized input independently: per input, register deb and counter cnt; at each edge, if sync2 == deb then cnt<=0; else if cnt == DEBOUNCE_CYCLES-1 then deb<=sync2 and cnt<=0; else cnt<=cnt+1.
REQ-017 SHALL register prev<=deb for each of the three debounced signals on every edge.
REQ-018 SHALL decode {deb_a,prev_a,deb_b,prev_b}: 1000 or 0111 = +STEP; 0010 or 1101 = -STEP; any other pattern (including both phases changing in one cycle) = no change.
REQ-019 SHALL apply the decoded step only to the channel selected by sel in that cycle; other channels hold.
REQ-020 SHALL, with SATURATE=1, compute value+STEP clamped to 2^WIDTH-1 and value-STEP clamped to 0, using a WIDTH+1-bit intermediate.
REQ-021 SHALL, with SATURATE=0, compute value±STEP modulo 2^WIDTH.
REQ-022 SHALL implement the select FSM with states SEL_R -> SEL_G -> SEL_B -> SEL_R, advancing one state per debounced button rising edge (deb_btn=1, prev_btn=0); a button release never advances.
REQ-023 SHALL, when a step and a button advance occur in the same cycle, apply the step to the channel selected before the advance and update sel on the same edge.
REQ-024 SHALL assert update for exactly one cycle following each edge where a channel register changed value; a clamped step (no change) SHALL NOT assert update.
REQ-025 SHALL have latency: a clean raw input edge occurring before clock edge 1 updates deb at edge DEBOUNCE_CYCLES+2 and the channel value at edge DEBOUNCE_CYCLES+3.
REQ-026 SHALL discard a pending debounce count when the input returns to deb before reaching DEBOUNCE_CYCLES-1, so that glitches shorter than DEBOUNCE_CYCLES cycles have no effect.

Reset
REQ-027 SHALL, while reset is high at an edge, clear all synchronizer, deb, prev and cnt registers to 0, set value_r, value_g and value_b to 0, set sel to 0 (SEL_R) and set update to 0.
REQ-028 SHALL let reset override any in-progress debounce, step or advance; the first post-reset edge is processed with inputs sampled fresh.
REQ-029 SHALL NOT generate a step or advance from reset release itself when the raw inputs are held low.

Verification (bench uses DEBOUNCE_CYCLES=4, WIDTH=8, STEP=1)
REQ-030 SHALL verify a clean increment: reset; hold b=0; raise a -> value_r 0->1 exactly at edge 7 after the a edge, update high for one cycle, sel=0.
REQ-031 SHALL verify a full clockwise detent sequence ×3, then a button press (held 10 cycles) -> sel=1, then one counter-clockwise detent -> value_g saturates at 0 with no update, value_r unchanged.
REQ-032 SHALL verify glitch rejection: a 3-cycle pulse on a, or 10 toggles each lasting ≤3 cycles, -> no value, sel or update change.
REQ-033 SHALL verify saturation and wrap: preload value_r=255 via steps, then +1 -> stays 255 with no update (SATURATE=1); with SATURATE=0 -> 0 with update.
REQ-034 SHALL verify sel wrap and coincidence: 3 presses -> sel 0->1->2->0; a step and a debounced press on the same edge -> the step lands on the old channel and sel advances.
REQ-035 SHALL verify reset mid-operation: assert reset with a debounce count pending and value_b=5 -> next edge all values 0, sel=0, update=0, and no step after release.
